// File: rtl/aes_round_sched_if.sv
// Bundle of the scheduler's bus-side handshake, datapath and status signals.
// blk_cnt exists only when AES_BLK_CNT_EN is defined.
interface aes_round_sched_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] plaintext;
   logic [127:0] cipher_key;
   logic [3:0]   key_idx;
   logic [127:0] dp_data;
   logic         dp_last_round;
   logic [127:0] dp_encrypted;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] ciphertext;
   logic         busy;
   logic [1:0]   dbg_state;
`ifdef AES_BLK_CNT_EN
   logic [15:0]  blk_cnt;

   modport slave (
      input  in_valid, plaintext, cipher_key, dp_encrypted, out_ready,
      output in_ready, key_idx, dp_data, dp_last_round, out_valid,
             ciphertext, busy, dbg_state, blk_cnt
   );
   modport master (
      output in_valid, plaintext, cipher_key, dp_encrypted, out_ready,
      input  in_ready, key_idx, dp_data, dp_last_round, out_valid,
             ciphertext, busy, dbg_state, blk_cnt
   );
`else
   modport slave (
      input  in_valid, plaintext, cipher_key, dp_encrypted, out_ready,
      output in_ready, key_idx, dp_data, dp_last_round, out_valid,
             ciphertext, busy, dbg_state
   );
   modport master (
      output in_valid, plaintext, cipher_key, dp_encrypted, out_ready,
      input  in_ready, key_idx, dp_data, dp_last_round, out_valid,
             ciphertext, busy, dbg_state
   );
`endif
endinterface

// File: rtl/aes_round_sched.sv
// Iterative AES round scheduler: round-0 AddRoundKey, then NR passes through a shared
// round datapath. Optional block counter enabled by defining AES_BLK_CNT_EN.
module aes_round_sched #(
   parameter int NR        = 10,
   parameter int ROUND_LAT = 1
) (
   input logic              clk,
   input logic              n_rst,
   aes_round_sched_if.slave bus
);

   // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
   // valid never depends on ready, and an offered block must be held until taken.

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int              LAT_W    = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROUND_LAT - 1);
   localparam logic [3:0]       RND_LAST = 4'(NR);

   state_t             state, state_nxt;
   logic [127:0]       state_reg, state_reg_nxt;
   logic [127:0]       ct_reg, ct_nxt;
   logic [3:0]         rnd, rnd_nxt;
   logic [LAT_W-1:0]   lat_cnt, lat_nxt;
   logic               accept;

   always_comb begin
      state_nxt     = state;
      state_reg_nxt = state_reg;
      ct_nxt        = ct_reg;
      rnd_nxt       = rnd;
      lat_nxt       = lat_cnt;
      accept        = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_valid) accept = 1'b1;
         end
         RUN: begin
            // Datapath result is only trusted on the last cycle of each round.
            if (lat_cnt == LAT_LAST) begin
               state_reg_nxt = bus.dp_encrypted;
               lat_nxt       = '0;
               if (rnd == RND_LAST) begin
                  ct_nxt    = bus.dp_encrypted;
                  state_nxt = DONE;
               end else begin
                  rnd_nxt = rnd + 4'd1;
               end
            end else begin
               lat_nxt = lat_cnt + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               if (bus.in_valid) accept = 1'b1;
               else              state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (accept) begin
         state_reg_nxt = bus.plaintext ^ bus.cipher_key;
         rnd_nxt       = 4'd1;
         lat_nxt       = '0;
         state_nxt     = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (n_rst) begin
         state     <= IDLE;
         state_reg <= '0;
         ct_reg    <= '0;
         rnd       <= '0;
         lat_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         state_reg <= state_reg_nxt;
         ct_reg    <= ct_nxt;
         rnd       <= rnd_nxt;
         lat_cnt   <= lat_nxt;
      end
   end

   assign bus.in_ready      = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign bus.dp_data       = state_reg;
   assign bus.key_idx       = (state == RUN) ? rnd : 4'd0;
   assign bus.dp_last_round = (state == RUN) && (rnd == RND_LAST);
   assign bus.out_valid     = (state == DONE);
   assign bus.ciphertext    = ct_reg;
   assign bus.busy          = (state != IDLE);
   assign bus.dbg_state     = state;

`ifdef AES_BLK_CNT_EN
   logic [15:0] blk_cnt_q;

   always_ff @(posedge clk) begin
      if (n_rst)                                  blk_cnt_q <= '0;
      else if ((state == DONE) && bus.out_ready)  blk_cnt_q <= blk_cnt_q + 16'd1;
   end

   assign bus.blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched with a pipelined stub round datapath (ROUND_LAT=3).
module tb_aes_round_sched;

  localparam int NR  = 10;
  localparam int LAT = 3;

  logic clk;
  logic n_rst;
  aes_round_sched_if bus();

  aes_round_sched #(.NR(NR), .ROUND_LAT(LAT)) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- stub datapath ----------------
  // Mode 0: state+1. Mode 1: rotate/xor mixing key_idx and last_round.
  int stub_mode;

  function automatic logic [127:0] round_f(input logic [127:0] s, input logic [3:0] r,
                                           input logic last, input int mode);
    logic [127:0] t;
    if (mode == 0) return s + 128'd1;
    t = {s[124:0], s[127:125]} ^ {32{r}};
    if (last) t = t ^ 128'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    return t;
  endfunction

  // Two register stages: the result for new inputs is visible only from the third cycle.
  logic [127:0] p0, p1;
  always @(posedge clk) begin
    p0 <= round_f(bus.dp_data, bus.key_idx, bus.dp_last_round, stub_mode);
    p1 <= p0;
  end
  assign bus.dp_encrypted = p1;

  // ---------------- reference model ----------------
  function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [127:0] key,
                                            input int mode);
    logic [127:0] s;
    s = pt ^ key;
    for (int r = 1; r <= NR; r++) s = round_f(s, 4'(r), r == NR, mode);
    return s;
  endfunction

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int n_cmp;
  int n_fail;
  int n_done;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_block(input logic [127:0] pt, input logic [127:0] key);
    int k;
    bus.plaintext  = pt;
    bus.cipher_key = key;
    bus.in_valid   = 1'b1;
    exp_q.push_back(model_ct(pt, key, stub_mode));
    k = 0;
    while (!bus.in_ready && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept_wait", 128'(k < 400), 128'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // n0 = cycles already elapsed since the accept edge (1 right after it).
  task automatic finish_block(input int n0, input int hold, input bit do_consume);
    int n, ki, seq_err, stab;
    logic [127:0] exp, held;
    n = n0;
    seq_err = 0;
    while (!bus.out_valid && n < 400) begin
      ki = (n - 1) / LAT + 1;
      if (bus.key_idx !== 4'(ki) || bus.dp_last_round !== (ki == NR) ||
          bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
        seq_err++;
      @(posedge clk); #1;
      n++;
    end
    check("latency", 128'(n), 128'(NR * LAT + 1));
    check("round_seq", 128'(seq_err), 128'd0);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 128'hDEAD;
    check("ciphertext", bus.ciphertext, exp);
    held = bus.ciphertext;
    stab = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.ciphertext !== held || bus.in_ready !== 1'b0) stab++;
    end
    check("hold_stable", 128'(stab), 128'd0);
    if (do_consume) begin
      bus.out_ready = 1'b1;
      #1;
      check("in_ready_on_consume", 128'(bus.in_ready), 128'd1);
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_done++;
      check("idle_after_consume", {126'd0, bus.out_valid, bus.busy}, 128'd0);
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b0;
    n_done = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    int           mode;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [127:0] pt, key;
    int k, hold;

    vecs[0] = '{128'h0, 128'h0, 0, 128'h0A};
    vecs[1] = '{{128{1'b1}}, 128'h0, 0, 128'h09};
    vecs[2] = '{128'h10, 128'h01, 0, 128'h1B};
    vecs[3] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                1, 128'h0};
    vecs[4] = '{128'hFFFF0000FFFF0000FFFF0000FFFF0000, 128'h0123456789ABCDEF0123456789ABCDEF,
                1, 128'h0};
    vecs[3].exp = model_ct(vecs[3].pt, vecs[3].key, 1);
    vecs[4].exp = model_ct(vecs[4].pt, vecs[4].key, 1);

    n_cmp = 0; n_fail = 0; n_done = 0;
    stub_mode = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.cipher_key = '0;
    do_reset();

    // Reset state
    check("rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_in_ready", 128'(bus.in_ready), 128'd1);
    check("rst_key_idx", 128'(bus.key_idx), 128'd0);
    check("rst_last", 128'(bus.dp_last_round), 128'd0);
    check("rst_dp_data", bus.dp_data, 128'd0);
    check("rst_ciphertext", bus.ciphertext, 128'd0);

    // Table-driven vectors: table expectation vs scoreboard/DUT
    for (int i = 0; i < 5; i++) begin
      stub_mode = vecs[i].mode;
      check("table_model", model_ct(vecs[i].pt, vecs[i].key, vecs[i].mode), vecs[i].exp);
      start_block(vecs[i].pt, vecs[i].key);
      finish_block(1, i % 3, 1'b1);
    end

    // Backpressure then same-cycle accept of the next block
    stub_mode = 1;
    start_block(128'hCAFEBABE, 128'h12345678);
    finish_block(1, 5, 1'b0);
    bus.plaintext  = 128'h0BADF00D;
    bus.cipher_key = 128'h55AA;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    exp_q.push_back(model_ct(128'h0BADF00D, 128'h55AA, stub_mode));
    #1;
    check("bp_in_ready_follows_out_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    n_done++;
    check("bp_reaccept_state", {126'd0, bus.out_valid, bus.busy}, 128'd1);
    finish_block(1, 0, 1'b1);

    // Reset asserted mid-operation at round 5
    stub_mode = 0;
    start_block(128'h777, 128'h1);
    k = 0;
    while (bus.key_idx !== 4'd5 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("reached_round5", 128'(bus.key_idx), 128'd5);
    n_rst = 1'b1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    n_done = 0;
    exp_q.delete();
    check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
    check("midrst_key_idx", 128'(bus.key_idx), 128'd0);
    check("midrst_busy", 128'(bus.busy), 128'd0);
    check("midrst_dp_data", bus.dp_data, 128'd0);
    check("midrst_ciphertext", bus.ciphertext, 128'd0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_output", 128'(bus.out_valid), 128'd0);
    start_block(128'h4242, 128'h0101);
    finish_block(1, 1, 1'b1);

    // in_valid offered during RUN must be ignored
    stub_mode = 1;
    start_block(128'hAAAA5555, 128'h3C3C);
    bus.plaintext  = 128'hFEEDFACE;
    bus.cipher_key = 128'h9999;
    bus.in_valid   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    finish_block(6, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("ignored_no_second_block", 128'(bus.busy), 128'd0);

    // Randomized blocks against the reference model
    for (int i = 0; i < 20; i++) begin
      stub_mode = int'($urandom_range(0, 1));
      pt  = {$urandom, $urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom, $urandom};
      hold = int'($urandom_range(0, 3));
      start_block(pt, key);
      finish_block(1, hold, 1'b1);
    end

`ifdef AES_BLK_CNT_EN
    check("blk_cnt", 128'(bus.blk_cnt), 128'(n_done[15:0]));
    do_reset();
    check("blk_cnt_rst", 128'(bus.blk_cnt), 128'd0);
    for (int i = 0; i < 3; i++) begin
      start_block(128'(i), 128'h5);
      finish_block(1, 0, 1'b1);
    end
    check("blk_cnt_3", 128'(bus.blk_cnt), 128'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
